chip8_rng_arbiter: RTL and testbench

Shares the CHIP-8 pseudo-random byte source among several requesters. Typical requesters are the CPU's CXNN execution path and the sprite/sound helpers. The block samples the free-running RNG byte into a small FIFO at a programmable decimation rate and serves requesters round-robin with a registered grant/data handshake, applying each requester's AND-mask. It also converts keypad events into a one-cycle stir pulse for the RNG's `user_input`.

---
 rtl/chip8_rng_arbiter.sv | 163 ++++++++++++++++
 tb/tb_chip8_rng_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_rng_arbiter.sv
// chip8_rng_arbiter
// Samples the free-running CHIP-8 RNG byte into a small FIFO every DIV
// cycles and hands bytes out round-robin to NREQ requesters. Each grant
// returns the head byte ANDed with that requester's mask. A keypad event is
// registered once and drives the RNG's user_input as a one-cycle stir pulse.
module chip8_rng_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int DIV   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rnd_in,
  input  logic                     key_event,
  output logic                     rnd_stir,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        mask,
  output logic [NREQ-1:0]          gnt,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [PW-1:0] RR_LAST  = PW'(NREQ - 1);
  localparam logic [PW-1:0] RR_ONE   = PW'(1);

  // Requester-specific view of a random byte.
  function automatic logic [7:0] apply_mask(input logic [7:0] b, input logic [7:0] m);
    return b & m;
  endfunction

  // Occupancy after one edge; a simultaneous push and pop leaves it unchanged.
  function automatic logic [LW-1:0] next_level(input logic [LW-1:0] lv,
                                               input logic push_i,
                                               input logic pop_i);
    logic [LW-1:0] r;
    r = lv;
    if (push_i && !pop_i) r = lv + LVL_ONE;
    else if (!push_i && pop_i) r = lv - LVL_ONE;
    return r;
  endfunction

  // Sampling and FIFO state
  logic [CW-1:0]   cnt_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [LW-1:0]   level_q;

  // Arbitration state and registered outputs
  logic [PW-1:0]   rr_q;
  logic [NREQ-1:0] gnt_p1;
  logic [7:0]      data_p1;
  logic            stir_p1;

  // Combinational decisions for the coming edge
  logic [NREQ-1:0] eff_req;
  logic            found;
  logic [PW-1:0]   sel;
  logic [NREQ-1:0] sel_onehot;
  logic [7:0]      sel_mask;
  logic            grant;
  logic            sample;
  logic            push;
  logic [NREQ-1:0] gnt_nxt;

  // Round-robin search from the pointer; the requester currently granted is
  // masked out so a level request held across its grant cycle is not served twice.
  always_comb begin
    int s;
    logic [PW-1:0] idx;
    s          = 0;
    idx        = '0;
    eff_req    = req & ~gnt_p1;
    found      = 1'b0;
    sel        = '0;
    sel_onehot = '0;
    sel_mask   = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(rr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = PW'(s);
      if (!found && eff_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found && (sel == PW'(i))) begin
        sel_onehot[i] = 1'b1;
        sel_mask      = mask[8*i +: 8];
      end
    end
  end

  // A grant needs a byte present before the edge; a full FIFO still accepts
  // the sample when the head is popped at the same edge.
  assign grant   = found && (level_q != '0);
  assign sample  = (cnt_q == CNT_LAST);
  assign push    = sample && ((level_q != LVL_FULL) || grant);
  assign gnt_nxt = grant ? sel_onehot : '0;

  // Free-running decimation counter, wraps at DIV-1 regardless of FIFO state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= sample ? '0 : cnt_q + CNT_ONE;
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      if (push)  tail_q <= tail_q + PTR_ONE;
      if (grant) head_q <= head_q + PTR_ONE;
      level_q <= next_level(level_q, push, grant);
    end
  end

  // FIFO storage; contents are qualified by level so need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= rnd_in;
  end

  // ---- stage p1: registered grant, masked byte and pointer advance ----
  // Data holds its last value between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_p1  <= '0;
      data_p1 <= '0;
      rr_q    <= '0;
    end else begin
      gnt_p1 <= gnt_nxt;
      if (grant) begin
        data_p1 <= apply_mask(mem[head_q], sel_mask);
        rr_q    <= (sel == RR_LAST) ? '0 : sel + RR_ONE;
      end
    end
  end

  // Keypad pulse delayed one cycle to stir the RNG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stir_p1 <= 1'b0;
    else        stir_p1 <= key_event;
  end

  assign gnt      = gnt_p1;
  assign data     = data_p1;
  assign rnd_stir = stir_p1;
  assign level    = level_q;

endmodule

// File: tb/tb_chip8_rng_arbiter.sv
// Testbench for chip8_rng_arbiter: a queue-based reference model predicts
// every edge; a separate monitor pops predictions and compares the DUT.
// A second instance with DIV=1 covers the empty-FIFO stall case.
module tb_chip8_rng_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int DIV   = 3;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           rnd_in = '0;
  logic                 key_event = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [8*NREQ-1:0]    mask = '0;
  logic                 rnd_stir;
  logic [NREQ-1:0]      gnt;
  logic [7:0]           data;
  logic [LW-1:0]        level;

  logic [NREQ-1:0]      req1 = 2'b11;
  logic [8*NREQ-1:0]    mask1 = 16'hFFFF;
  logic                 rnd_stir1;
  logic [NREQ-1:0]      gnt1;
  logic [7:0]           data1;
  logic [LW-1:0]        level1;

  always #5 clk = ~clk;

  chip8_rng_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .key_event(key_event),
    .rnd_stir(rnd_stir), .req(req), .mask(mask), .gnt(gnt), .data(data),
    .level(level)
  );

  chip8_rng_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .key_event(key_event),
    .rnd_stir(rnd_stir1), .req(req1), .mask(mask1), .gnt(gnt1), .data(data1),
    .level(level1)
  );

  typedef struct {
    int              n;
    logic [NREQ-1:0] g;
    logic [7:0]      d;
    logic [LW-1:0]   lv;
    logic            st;
  } exp_t;

  exp_t gq[$];
  exp_t st_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n;
  logic mon_en = 1'b0;

  // Reference model state
  logic [7:0]      byte_q[$];
  int              m_cnt;
  int              m_ptr;
  logic [NREQ-1:0] m_gnt;
  logic [7:0]      m_data;
  logic            m_stir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    byte_q.delete();
    m_cnt  = 0;
    m_ptr  = 0;
    m_gnt  = '0;
    m_data = '0;
    m_stir = 1'b0;
  endtask

  // One edge of behaviour: serve one requester from the head, then take the sample.
  task automatic model_step(input logic [NREQ-1:0] rq, input logic [8*NREQ-1:0] mk,
                            input logic [7:0] rn, input logic kev);
    logic [NREQ-1:0] eff;
    int sel;
    exp_t e;
    eff = rq & ~m_gnt;
    sel = -1;
    if (byte_q.size() > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (sel < 0 && eff[i]) sel = i;
      end
    end
    if (sel >= 0) begin
      m_data = byte_q.pop_front() & mk[8*sel +: 8];
      m_gnt  = NREQ'(1 << sel);
      m_ptr  = (sel + 1) % NREQ;
    end else begin
      m_gnt = '0;
    end
    if (m_cnt == DIV - 1 && byte_q.size() < DEPTH) byte_q.push_back(rn);
    m_cnt  = (m_cnt + 1) % DIV;
    m_stir = kev;
    e.n  = edge_n + 1;
    e.g  = m_gnt;
    e.d  = m_data;
    e.lv = LW'(byte_q.size());
    e.st = m_stir;
    st_q.push_back(e);
    if (m_gnt != '0) gq.push_back(e);
  endtask

  // Apply inputs for the next edge, predict it, then wait until after it.
  task automatic drive(input logic [NREQ-1:0] rq, input logic [8*NREQ-1:0] mk,
                       input logic [7:0] rn, input logic kev);
    req = rq;
    mask = mk;
    rnd_in = rn;
    key_event = kev;
    model_step(rq, mk, rn, kev);
    @(negedge clk);
  endtask

  // Monitor: compares every edge's state and every presented grant.
  initial begin
    exp_t s;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        if (st_q.size() > 0) begin
          s = st_q.pop_front();
          chk("state_edge", 32'(s.n), 32'(edge_n));
          chk("state_gnt", 32'(gnt), 32'(s.g));
          chk("state_data", 32'(data), 32'(s.d));
          chk("state_level", 32'(level), 32'(s.lv));
          chk("state_stir", 32'(rnd_stir), 32'(s.st));
        end
        if (gnt != '0) begin
          if (gq.size() == 0) begin
            chk("gnt_unexpected", 32'(gnt), 32'h0);
          end else begin
            g = gq.pop_front();
            chk("gnt_edge", 32'(edge_n), 32'(g.n));
            chk("gnt_onehot", 32'(gnt), 32'(g.g));
            chk("gnt_data", 32'(data), 32'(g.d));
          end
        end else if (gq.size() > 0 && gq[0].n <= edge_n) begin
          g = gq.pop_front();
          chk("gnt_missed", 32'(gnt), 32'(g.g));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rr_g [5];
    logic [7:0]      rr_d [5];
    logic [NREQ-1:0] rq;
    logic [8*NREQ-1:0] mk;
    bit got;
    rr_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    rr_d = '{8'h08, 8'h0B, 8'h0E, 8'h11, 8'h14};
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_data", 32'(data), 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Fill with incrementing bytes, stir pulses at cycles 10/11, DIV=1 stall on u_dut1
    for (int i = 0; i < 14; i++) begin
      drive(2'b00, 16'h0F0F, 8'(i), (i == 9 || i == 10));
      if ((i + 1) % 3 == 0) chk("fill_level", 32'(level), 32'((i + 1) / 3));
      if (i == 13) chk("fill_level_sat", 32'(level), 32'd4);
      if (i == 9 || i == 10) chk("stir_high", 32'(rnd_stir), 32'h1);
      if (i == 11) chk("stir_low", 32'(rnd_stir), 32'h0);
      if (i == 0) begin
        chk("div1_no_early_gnt", 32'(gnt1), 32'h0);
        chk("div1_level_first", 32'(level1), 32'h1);
      end else if (i < 8) begin
        chk("div1_gnt", 32'(gnt1), (i % 2 == 1) ? 32'h1 : 32'h2);
        chk("div1_data", 32'(data1), 32'(i - 1));
        chk("div1_level", 32'(level1), 32'h1);
      end
    end

    // Single request with mask 0x0F; this edge also pushes into the full FIFO
    drive(2'b01, 16'hFF0F, 8'd14, 1'b0);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_data", 32'(data), 32'h02);
    chk("pushpop_full_level", 32'(level), 32'd4);
    drive(2'b01, 16'hFF0F, 8'd15, 1'b0);
    chk("single_no_double", 32'(gnt), 32'h0);
    drive(2'b01, 16'hFF0F, 8'd16, 1'b0);
    chk("single_next_gnt", 32'(gnt), 32'h1);
    chk("single_next_data", 32'(data), 32'h05);
    drive(2'b00, 16'hFF0F, 8'd17, 1'b0);
    chk("refill_level", 32'(level), 32'd4);

    // Round robin on a full FIFO, pointer currently at requester 1
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 16'hFFFF, 8'(18 + i), 1'b0);
      chk("rr_gnt", 32'(gnt), 32'(rr_g[i]));
      chk("rr_data", 32'(data), 32'(rr_d[i]));
    end
    drive(2'b11, 16'hFFFF, 8'd23, 1'b0);
    chk("empty_stall_gnt", 32'(gnt), 32'h0);
    chk("empty_stall_level", 32'(level), 32'h1);

    // Randomized traffic, including zero masks and dense request phases
    for (int c = 0; c < 600; c++) begin
      rq = (c % 100 < 30) ? 2'b11 : NREQ'($urandom);
      mk = 16'($urandom);
      if ($urandom_range(0, 7) == 0) mk[7:0] = 8'h00;
      drive(rq, mk, 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of a grant
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      drive(2'b11, 16'hFFFF, 8'($urandom_range(1, 255)), 1'b0);
      if (gnt != '0) got = 1'b1;
    end
    if (!got) chk("reset_setup_gnt", 32'(gnt), 32'h1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_data", 32'(data), 32'h0);
    chk("async_rst_level", 32'(level), 32'h0);
    chk("async_rst_stir", 32'(rnd_stir), 32'h0);
    chk("async_rst_level1", 32'(level1), 32'h0);
    chk("grant_queue_drained", 32'(gq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
